// File: rtl/action_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  action_dispatcher_pkg
//  Shared definitions for the action dispatcher: the eight 3-bit action
//  codes, the winner codes and the round-sequencing FSM state type.
//  Revision: 1.0  initial release
// ============================================================================
package action_dispatcher_pkg;

   localparam logic [2:0] ACT_KICK   = 3'b000;
   localparam logic [2:0] ACT_PUNCH  = 3'b001;
   localparam logic [2:0] ACT_AWAIT  = 3'b010;
   localparam logic [2:0] ACT_JUMP   = 3'b011;
   localparam logic [2:0] ACT_LEFT1  = 3'b100;
   localparam logic [2:0] ACT_LEFT2  = 3'b101;
   localparam logic [2:0] ACT_RIGHT1 = 3'b110;
   localparam logic [2:0] ACT_RIGHT2 = 3'b111;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   // A player whose health bus reads zero has lost.
   function automatic logic [1:0] winner_code(input logic p1_dead, input logic p2_dead);
      logic [1:0] code;
      code = WIN_NONE;
      if (p1_dead && p2_dead) code = WIN_DRAW;
      else if (p2_dead)       code = WIN_P1;
      else if (p1_dead)       code = WIN_P2;
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/action_dispatcher_button_debouncer.sv
`default_nettype none
// ============================================================================
//  button_debouncer
//  Two-flop synchronizer followed by a stability counter. The synchronized
//  level must differ from the accepted level for DEBOUNCE_CYCLES consecutive
//  cycles before it is accepted; an accepted 0->1 change produces a
//  one-cycle pulse on rise.
//  Ports:
//    clk     in   clock
//    reset   in   asynchronous, active-low reset
//    button  in   raw asynchronous pushbutton, active-high
//    rise    out  one-cycle pulse on debounced rising edge
//  Revision: 1.0  initial release
// ============================================================================
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
         rise  <= 1'b0;
         // Any cycle agreeing with the accepted level restarts the count,
         // so a glitch shorter than DEBOUNCE_CYCLES is discarded.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/action_dispatcher.sv
`default_nettype none
// ============================================================================
//  action_dispatcher
//  Debounces both players' commit buttons, latches their selected actions
//  and, once both have committed, dispatches action1/action2 with an
//  ENABLE_CYCLES-long action_enable pulse followed by a GAP_CYCLES low gap.
//  Health is checked on the final gap cycle; a zero health bus ends the game
//  with a sticky game_over and winner code.
//  Optional feature macro: ACTION_TIMEOUT_EN -- when defined, if only one
//  player has committed for TIMEOUT_CYCLES idle cycles, the other player is
//  forced to await and the round is dispatched.
//  Ports:
//    clk, reset               clock, asynchronous active-low reset
//    commit1, commit2         raw commit pushbuttons
//    sel1, sel2 [2:0]         action select switches
//    health1, health2 [1:0]   player health buses
//    action1, action2 [2:0]   dispatched actions
//    action_enable            round strobe (registered)
//    game_over, winner [1:0]  sticky end-of-game flag and winner code
//    round_count [7:0]        rounds dispatched, saturating at 255
//  Revision: 1.0  initial release
// ============================================================================
module action_dispatcher
   import action_dispatcher_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ENABLE_CYCLES   = 2,
   parameter int GAP_CYCLES      = 2,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       commit1,
   input  logic       commit2,
   input  logic [2:0] sel1,
   input  logic [2:0] sel2,
   input  logic [1:0] health1,
   input  logic [1:0] health2,
   output logic [2:0] action1,
   output logic [2:0] action2,
   output logic       action_enable,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [7:0] round_count
);

   localparam int PMAX = (ENABLE_CYCLES > GAP_CYCLES) ? ENABLE_CYCLES : GAP_CYCLES;
   localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam logic [PW-1:0] EN_LAST  = PW'(ENABLE_CYCLES - 1);
   localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYCLES - 1);

   logic          pulse1;
   logic          pulse2;
   logic [2:0]    pend1;
   logic [2:0]    pend2;
   logic          armed1;
   logic          armed2;
   logic          go;
   logic          dispatch;
   logic          p1_dead;
   logic          p2_dead;
   logic [PW-1:0] phase_cnt;
   state_t        state;
   state_t        state_next;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
      .clk    (clk),
      .reset  (reset),
      .button (commit1),
      .rise   (pulse1)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
      .clk    (clk),
      .reset  (reset),
      .button (commit2),
      .rise   (pulse2)
   );

   assign p1_dead = (health1 == 2'b00);
   assign p2_dead = (health2 == 2'b00);

`ifdef ACTION_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_wait;
   logic          one_armed;

   assign one_armed = armed1 ^ armed2;

   // Counts idle cycles spent with exactly one player committed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_wait <= '0;
      end else if (dispatch || !(state == ST_IDLE && one_armed)) begin
         idle_wait <= '0;
      end else begin
         idle_wait <= idle_wait + TW'(1);
      end
   end

   assign go = (armed1 && armed2) || (one_armed && (idle_wait == TW'(TIMEOUT_CYCLES)));
`else
   assign go = armed1 && armed2;
`endif

   // ---------------------------------------------------------------- FSM --
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      dispatch   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (go) begin
               state_next = ST_DRIVE;
               dispatch   = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (phase_cnt == EN_LAST) state_next = ST_GAP;
         end
         ST_GAP: begin
            // Health is only trusted here: players act on the first enabled
            // edge, so their buses have settled by the end of the gap.
            if (phase_cnt == GAP_LAST) state_next = (p1_dead || p2_dead) ? ST_OVER : ST_IDLE;
         end
         ST_OVER: begin
            state_next = ST_OVER;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_cnt <= '0;
      end else if (state_next != state) begin
         phase_cnt <= '0;
      end else if (state == ST_DRIVE || state == ST_GAP) begin
         phase_cnt <= phase_cnt + PW'(1);
      end
   end

   // ------------------------------------------------------ commit capture --
   // A pulse landing on the dispatch cycle wins over the clear, so it is
   // carried into the next round rather than lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend1  <= ACT_AWAIT;
         pend2  <= ACT_AWAIT;
         armed1 <= 1'b0;
         armed2 <= 1'b0;
      end else begin
         if (pulse1 && state != ST_OVER) begin
            pend1  <= sel1;
            armed1 <= 1'b1;
         end else if (dispatch) begin
            armed1 <= 1'b0;
         end
         if (pulse2 && state != ST_OVER) begin
            pend2  <= sel2;
            armed2 <= 1'b1;
         end else if (dispatch) begin
            armed2 <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------ outputs --
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         action1       <= ACT_AWAIT;
         action2       <= ACT_AWAIT;
         action_enable <= 1'b0;
         game_over     <= 1'b0;
         winner        <= WIN_NONE;
         round_count   <= 8'd0;
      end else begin
         action_enable <= (state_next == ST_DRIVE);
         game_over     <= (state_next == ST_OVER);
         if (dispatch) begin
            // An unarmed player can only reach dispatch through the timeout.
            action1 <= armed1 ? pend1 : ACT_AWAIT;
            action2 <= armed2 ? pend2 : ACT_AWAIT;
            if (round_count != 8'hFF) round_count <= round_count + 8'd1;
         end
         if (state_next == ST_OVER && state != ST_OVER) begin
            winner <= winner_code(p1_dead, p2_dead);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_action_dispatcher.sv
`default_nettype none
// ============================================================================
//  tb_action_dispatcher
//  Randomized round-level bench for action_dispatcher. Stimulus tasks update
//  a round model and push the expected dispatch into a scoreboard; an
//  independent monitor pops and compares on each action_enable rising edge.
//  Honours ACTION_TIMEOUT_EN for the single-commit scenario.
//  Revision: 1.0  initial release
// ============================================================================
module tb_action_dispatcher;
   import action_dispatcher_pkg::*;

   localparam int DB  = 4;
   localparam int EN  = 2;
   localparam int GAP = 2;
   localparam int TO  = 1000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       commit1 = 1'b0;
   logic       commit2 = 1'b0;
   logic [2:0] sel1 = 3'd0;
   logic [2:0] sel2 = 3'd0;
   logic [1:0] health1 = 2'b11;
   logic [1:0] health2 = 2'b11;
   logic [2:0] action1;
   logic [2:0] action2;
   logic       action_enable;
   logic       game_over;
   logic [1:0] winner;
   logic [7:0] round_count;

   always #5 clk = ~clk;

   action_dispatcher #(
      .DEBOUNCE_CYCLES (DB),
      .ENABLE_CYCLES   (EN),
      .GAP_CYCLES      (GAP),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .commit1       (commit1),
      .commit2       (commit2),
      .sel1          (sel1),
      .sel2          (sel2),
      .health1       (health1),
      .health2       (health2),
      .action1       (action1),
      .action2       (action2),
      .action_enable (action_enable),
      .game_over     (game_over),
      .winner        (winner),
      .round_count   (round_count)
   );

   int checks = 0;
   int passed = 0;
   int pulses = 0;

   typedef struct packed {
      logic [2:0] a1;
      logic [2:0] a2;
      logic [7:0] rc;
   } exp_t;
   exp_t expq[$];

   // Round-level model: pending selection and commit state per player.
   logic [2:0] m_pend[2];
   bit         m_armed[2];
   int         m_rounds;
   bit         m_over;
   logic [1:0] m_win;

   task automatic check(string name, int actual, int required);
      checks++;
      if (actual == required) passed++;
      else $display("FAIL %s: actual %0d required %0d", name, actual, required);
   endtask

   function automatic void model_reset();
      m_armed[0] = 0; m_armed[1] = 0;
      m_rounds = 0; m_over = 0; m_win = WIN_NONE;
   endfunction

   function automatic void model_dispatch(logic [1:0] h1, logic [1:0] h2);
      exp_t e;
      e.a1 = m_armed[0] ? m_pend[0] : ACT_AWAIT;
      e.a2 = m_armed[1] ? m_pend[1] : ACT_AWAIT;
      m_rounds = (m_rounds < 255) ? m_rounds + 1 : 255;
      e.rc = 8'(m_rounds);
      expq.push_back(e);
      m_armed[0] = 0; m_armed[1] = 0;
      if (h1 == 2'b00 || h2 == 2'b00) begin
         m_over = 1;
         m_win  = (h1 == 2'b00 && h2 == 2'b00) ? WIN_DRAW :
                  (h2 == 2'b00) ? WIN_P1 : WIN_P2;
      end
   endfunction

   function automatic void model_press(bit p1, bit p2, logic [2:0] s1, logic [2:0] s2);
      if (m_over) return;
      if (p1) begin m_pend[0] = s1; m_armed[0] = 1; end
      if (p2) begin m_pend[1] = s2; m_armed[1] = 1; end
      if (m_armed[0] && m_armed[1]) model_dispatch(health1, health2);
   endfunction

   // Hold the selected buttons for 'hold' cycles, then release long enough
   // for the release to be debounced too.
   task automatic press(bit p1, bit p2, logic [2:0] s1, logic [2:0] s2, int hold);
      if (hold >= DB) model_press(p1, p2, s1, s2);
      @(posedge clk); #1;
      if (p1) begin sel1 = s1; commit1 = 1'b1; end
      if (p2) begin sel2 = s2; commit2 = 1'b1; end
      repeat (hold) @(posedge clk);
      #1;
      if (p1) commit1 = 1'b0;
      if (p2) commit2 = 1'b0;
      repeat (DB + 6) @(posedge clk);
   endtask

   task automatic wait_enable(int bound);
      int n;
      n = 0;
      @(negedge clk);
      while (!action_enable && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!action_enable) begin
         checks++;
         $display("FAIL wait_enable: action_enable actual 0 required 1 within %0d cycles", bound);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ monitor --
   bit         prev_en;
   int         hi_cnt;
   int         lo_cnt;
   bit         seen_fall;
   logic [2:0] held_a1;
   logic [2:0] held_a2;

   always @(negedge clk) begin
      if (!reset) begin
         prev_en = 0; hi_cnt = 0; lo_cnt = 0; seen_fall = 0;
      end else begin
         if (action_enable && !prev_en) begin
            pulses++;
            if (seen_fall) begin
               checks++;
               if (lo_cnt >= GAP) passed++;
               else $display("FAIL gap_len: actual %0d required >= %0d", lo_cnt, GAP);
            end
            if (expq.size() == 0) begin
               checks++;
               $display("FAIL unexpected_pulse: actual pulse with action1=%0d action2=%0d required none",
                        action1, action2);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("action1", action1, e.a1);
               check("action2", action2, e.a2);
               check("round_count", round_count, e.rc);
            end
            held_a1 = action1;
            held_a2 = action2;
            hi_cnt  = 1;
         end else if (action_enable) begin
            hi_cnt++;
            check("action1_stable", action1, held_a1);
            check("action2_stable", action2, held_a2);
         end else if (prev_en) begin
            check("enable_width", hi_cnt, EN);
            seen_fall = 1;
            lo_cnt    = 1;
         end else begin
            lo_cnt++;
         end
         prev_en = action_enable;
      end
   end

   // ----------------------------------------------------------- stimulus --
   initial begin
      int base;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_action1", action1, ACT_AWAIT);
      check("rst_action2", action2, ACT_AWAIT);
      check("rst_enable", action_enable, 0);
      check("rst_game_over", game_over, 0);
      check("rst_winner", winner, WIN_NONE);
      check("rst_round_count", round_count, 0);
      reset = 1'b1;

      // Basic round, then randomized rounds.
      press(1, 1, ACT_KICK, ACT_PUNCH, 8);
      check("first_round_count", round_count, 1);
      for (int i = 0; i < 8; i++) begin
         press(1, 1, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 6 + $urandom_range(4, 0));
      end

      // Short glitch must not arm; a 6-cycle hold arms exactly once.
      base = pulses;
      press(1, 0, ACT_LEFT2, 3'd0, 3);
      press(0, 1, 3'd0, ACT_JUMP, 8);
      repeat (50) @(posedge clk);
      check("glitch_no_dispatch", pulses, base);
      press(1, 0, ACT_RIGHT1, 3'd0, 6);
      repeat (10) @(posedge clk);
      check("hold_one_dispatch", pulses, base + 1);

      // Single commit.
      base = pulses;
      press(1, 0, ACT_LEFT1, 3'd0, 8);
`ifdef ACTION_TIMEOUT_EN
      model_dispatch(health1, health2);
      repeat (3000) @(posedge clk);
      check("timeout_dispatch", pulses, base + 1);
`else
      repeat (3000) @(posedge clk);
      check("no_timeout_dispatch", pulses, base);
      press(0, 1, 3'd0, ACT_RIGHT2, 8);
      repeat (10) @(posedge clk);
      check("late_commit_dispatch", pulses, base + 1);
`endif

      // Re-press of commit1 during DRIVE is carried into the next round.
      press(1, 0, ACT_JUMP, 3'd0, 8);
      fork
         press(0, 1, 3'd0, ACT_KICK, 8);
         begin
            wait_enable(40);
            press(1, 0, ACT_RIGHT1, 3'd0, 6);
         end
      join
      press(0, 1, 3'd0, ACT_LEFT2, 8);

      // Player 2 loses.
      health2 = 2'b00;
      press(1, 1, ACT_PUNCH, ACT_AWAIT, 8);
      repeat (10) @(posedge clk);
      check("p1_win_game_over", game_over, 1);
      check("p1_win_winner", winner, m_win);
      base = pulses;
      press(1, 1, ACT_KICK, ACT_KICK, 8);
      repeat (20) @(posedge clk);
      check("over_no_pulse", pulses, base);
      check("over_round_count", round_count, m_rounds);

      // Draw.
      do_reset();
      check("rst2_game_over", game_over, 0);
      check("rst2_round_count", round_count, 0);
      health1 = 2'b00;
      health2 = 2'b00;
      reset = 1'b1;
      press(1, 1, ACT_JUMP, ACT_JUMP, 8);
      repeat (10) @(posedge clk);
      check("draw_game_over", game_over, 1);
      check("draw_winner", winner, WIN_DRAW);

      // Reset in the middle of DRIVE.
      do_reset();
      health1 = 2'b11;
      health2 = 2'b11;
      reset = 1'b1;
      fork
         press(1, 1, ACT_PUNCH, ACT_RIGHT1, 8);
         begin
            wait_enable(40);
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            check("midrst_enable", action_enable, 0);
            check("midrst_action1", action1, ACT_AWAIT);
            check("midrst_action2", action2, ACT_AWAIT);
            check("midrst_round_count", round_count, 0);
         end
      join
      model_reset();
      reset = 1'b1;
      repeat (5) @(posedge clk);

      check("scoreboard_drained", expq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/action_dispatcher.md
# action_dispatcher

Front end of the fighting-game datapath that drives both player modules. Debounces each player's commit button, latches the selected 3-bit action, and once both players have committed, presents `action1`/`action2` with a timed `action_enable` pulse followed by a mandatory low gap. Each player module therefore re-arms and acts exactly once per round. It watches both health buses and raises a sticky `game_over` with a winner code.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: cycles a synchronized button must hold stable before its level is accepted.
- `ENABLE_CYCLES`, 2: cycles `action_enable` is held high per round (≥1).
- `GAP_CYCLES`, 2: cycles `action_enable` is held low after each pulse (≥1).
- `TIMEOUT_CYCLES`, 1000: idle-wait limit, used only with `ACTION_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `commit1`, `commit2`  in  1  raw pushbuttons, active-high, asynchronous
- `sel1`, `sel2`  in  3  action select switches (action encoding)
- `health1`, `health2`  in  2  health from the player modules
- `action1`, `action2`  out  3  dispatched actions
- `action_enable`  out  1  round strobe to both players
- `game_over`  out  1  sticky end-of-game flag
- `winner`  out  2  00 none, 01 player 1, 10 player 2, 11 draw
- `round_count`  out  8  rounds dispatched, saturating

## Operation
- Action codes: kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111.
- Commit path: 2-FF synchronizer, then a stability counter. The debounced rising edge gives a one-cycle pulse.
- On the pulse, `selN` is copied to `pendN` and `armedN` is set. A re-press before dispatch overwrites `pendN`.
- FSM states:
  - IDLE → DRIVE when `armed1 && armed2`. On that edge: `actionN <= pendN`, both armed flags clear, `round_count` increments and saturates at 255.
  - DRIVE holds `action_enable`=1 for `ENABLE_CYCLES`, then → GAP.
  - GAP holds `action_enable`=0 for `GAP_CYCLES`. On its last cycle:
    - If `health1==0 || health2==0` → OVER.
    - Otherwise → IDLE.
  - OVER is terminal until reset. `game_over`=1. `winner` = 11 if both health buses are 0, 01 if only `health2==0`, 10 if only `health1==0`.
- Commits during DRIVE/GAP are captured for the next round. Commits in OVER are ignored.
- `action1`/`action2` hold their value from dispatch until the next dispatch. They never change while `action_enable`=1.

## Timing
- Reset values: `action1`=`action2`=010 (await), `action_enable`=0, `game_over`=0, `winner`=00, `round_count`=0, FSM=IDLE, armed flags clear, all counters 0.
- Reset is asynchronous and takes effect immediately, including mid-DRIVE. `action_enable` drops in the same instant.
- Press to armed: 2 sync cycles + `DEBOUNCE_CYCLES` + 1.
- Armed-both to `action_enable` high: 1 cycle. `action_enable` is registered.
- Minimum round period: 1 + `ENABLE_CYCLES` + `GAP_CYCLES`.
- Simultaneous commit pulses in the same cycle are both accepted.
- Health is sampled only in the final GAP cycle. Players update on the first enabled edge, so their health values are settled by then.

## Configuration
- `ACTION_TIMEOUT_EN` defined:
  - In IDLE, a counter starts once exactly one player is armed.
  - When the counter reaches `TIMEOUT_CYCLES`, the unarmed player's action is forced to await (010) and dispatch proceeds as normal.
  - The counter clears on dispatch and on reset.
- `ACTION_TIMEOUT_EN` undefined: no counter. IDLE waits indefinitely for both commits.

## Structure
- Shared package holds:
  - the eight action code constants
  - the winner codes
  - the FSM state typedef (IDLE, DRIVE, GAP, OVER)
- Sub-module `button_debouncer` (synchronizer, stability counter, rise-pulse output, parameter `DEBOUNCE_CYCLES`), instantiated once per player.

## Test plan
- `sel1`=000, `sel2`=001, press both commits → `action1`=000, `action2`=001, `action_enable` high exactly 2 cycles then low 2 cycles, `round_count`=1.
- Press only `commit1`, hold 3000 cycles without the macro → no `action_enable`. With `ACTION_TIMEOUT_EN` → dispatch after 1000 cycles with `action2`=010.
- Glitch `commit1` high for 3 cycles → not armed. Hold it 6 cycles → armed once.
- `health2` driven to 00 during DRIVE → on the last GAP cycle `game_over`=1, `winner`=01. Further commits produce no pulses.
- `health1`=`health2`=00 → `winner`=11. Assert reset mid-DRIVE → `action_enable`=0, `action1`=`action2`=010, `round_count`=0.
- Press both commits, then re-press `commit1` with `sel1`=110 during DRIVE → the next round dispatches `action1`=110.
